// File: rtl/timer_pkg.sv
// Timer peripheral shared types: register select, offsets,
// CR/SR bit positions and reset values.
package timer_pkg;

  typedef enum logic [2:0] {
    TIMER_NONE,
    TIMER_CR,
    TIMER_SR,
    TIMER_CNTR,
    TIMER_CMPR
  } timer_reg_t;

  localparam logic [3:0] TIMER_OFF_CR   = 4'h0;
  localparam logic [3:0] TIMER_OFF_SR   = 4'h4;
  localparam logic [3:0] TIMER_OFF_CNTR = 4'h8;
  localparam logic [3:0] TIMER_OFF_CMPR = 4'hC;

  localparam int CR_EN       = 0;
  localparam int CR_ONE_SHOT = 1;
  localparam int CR_IRQ_EN   = 2;
  localparam int CR_PSC_LSB  = 8;

  localparam int SR_MATCH = 0;

  localparam logic [31:0] CMPR_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..psc while en, pulses tick at psc.
// Ports: clk, rst_n, en, clr (restart), psc, tick.
module timer_prescaler #(
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PSC_WIDTH-1:0] psc,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] cnt;

  assign tick = en && (cnt == psc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Timer register file + counting engine.
// Ports: clk, rst_n, requested_reg, we, wdata -> rdata, irq.
module timer_core
  import timer_pkg::*;
#(
  parameter int PSC_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  timer_reg_t  requested_reg,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic                 cr_en;
  logic                 cr_os;
  logic                 cr_ie;
  logic [PSC_WIDTH-1:0] cr_psc;
  logic                 sr_match;
  logic [31:0]          cntr;
  logic [31:0]          cmpr;
  logic                 tick;
  logic                 hit;
  logic                 access;
  logic                 sel_cr;
  logic                 sel_sr;
  logic                 sel_cntr;
  logic                 sel_cmpr;
  logic [31:0]          cr_val;
  logic [31:0]          rd_val;

  assign access   = requested_reg != TIMER_NONE;
  assign sel_cr   = requested_reg == TIMER_CR;
  assign sel_sr   = requested_reg == TIMER_SR;
  assign sel_cntr = requested_reg == TIMER_CNTR;
  assign sel_cmpr = requested_reg == TIMER_CMPR;

  assign hit = tick && (cntr == cmpr);
  assign irq = sr_match & cr_ie;

  timer_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_psc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cr_en),
    .clr  (sel_cr && we),
    .psc  (cr_psc),
    .tick (tick)
  );

  always_comb begin
    cr_val = '0;
    cr_val[CR_EN] = cr_en;
    cr_val[CR_ONE_SHOT] = cr_os;
    cr_val[CR_IRQ_EN] = cr_ie;
    cr_val[CR_PSC_LSB +: PSC_WIDTH] = cr_psc;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_cr:   rd_val = cr_val;
      sel_sr:   rd_val[SR_MATCH] = sr_match;
      sel_cntr: rd_val = cntr;
      sel_cmpr: rd_val = cmpr;
      default:  rd_val = '0;
    endcase
  end

  // Bus write beats the one-shot EN clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_en  <= 1'b0;
      cr_os  <= 1'b0;
      cr_ie  <= 1'b0;
      cr_psc <= '0;
    end else if (sel_cr && we) begin
      cr_en  <= wdata[CR_EN];
      cr_os  <= wdata[CR_ONE_SHOT];
      cr_ie  <= wdata[CR_IRQ_EN];
      cr_psc <= wdata[CR_PSC_LSB +: PSC_WIDTH];
    end else if (hit && cr_os) begin
      cr_en  <= 1'b0;
    end
  end

  // A new match beats W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_match <= 1'b0;
    end else if (hit) begin
      sr_match <= 1'b1;
    end else if (sel_sr && we && wdata[SR_MATCH]) begin
      sr_match <= 1'b0;
    end
  end

  // Bus write beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr <= '0;
    end else if (sel_cntr && we) begin
      cntr <= wdata;
    end else if (hit) begin
      cntr <= '0;
    end else if (tick) begin
      cntr <= cntr + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmpr <= CMPR_RST;
    end else if (sel_cmpr && we) begin
      cmpr <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (access && !we) begin
      rdata <= rd_val;
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core with a one-deep
// read-data scoreboard checked in the rvalid cycle.
module tb_timer_core;
  import timer_pkg::*;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  timer_reg_t  requested_reg = TIMER_NONE;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int  n_tests = 0;
  int  n_fail = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  timer_core #(
    .PSC_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .requested_reg(requested_reg),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata),
    .irq          (irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  // One bus cycle: retire last access, then drive a new one.
  task automatic cyc(input timer_reg_t r, input logic w,
                     input logic [31:0] d,
                     input logic [31:0] e,
                     input string tag);
    sb_t s;
    @(negedge clk);
    if (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.tag, rdata, s.exp);
    end
    requested_reg = r;
    we = w;
    wdata = d;
    sb.push_back('{e, tag});
  endtask

  task automatic rd(input timer_reg_t r,
                    input logic [31:0] e,
                    input string tag);
    cyc(r, 1'b0, 32'h0, e, tag);
  endtask

  task automatic wr(input timer_reg_t r,
                    input logic [31:0] d);
    cyc(r, 1'b1, d, 32'h0, "wr_rdata");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    chk_irq("rst_irq", 1'b0);
    rst_n = 1'b1;

    rd(TIMER_CR, 32'h0, "rst_cr");
    rd(TIMER_SR, 32'h0, "rst_sr");
    rd(TIMER_CNTR, 32'h0, "rst_cntr");
    rd(TIMER_CMPR, 32'hFFFF_FFFF, "rst_cmpr");
    chk_irq("rst_irq2", 1'b0);

    // Periodic, PSC=0, CMPR=3
    wr(TIMER_CMPR, 32'd3);
    wr(TIMER_CR, 32'h5);
    rd(TIMER_CNTR, 32'd0, "per_c0");
    chk_irq("per_irq0", 1'b0);
    rd(TIMER_CNTR, 32'd1, "per_c1");
    rd(TIMER_CNTR, 32'd2, "per_c2");
    rd(TIMER_CNTR, 32'd3, "per_c3");
    chk_irq("per_irq3", 1'b0);
    rd(TIMER_CNTR, 32'd0, "per_wrap");
    chk_irq("per_irq_rise", 1'b1);
    wr(TIMER_SR, 32'h1);
    wr(TIMER_CR, 32'h0);
    chk_irq("per_irq_fall", 1'b0);

    // One-shot, PSC=2, CMPR=1
    wr(TIMER_CMPR, 32'd1);
    wr(TIMER_CNTR, 32'd0);
    wr(TIMER_CR, 32'h0000_0203);
    rd(TIMER_CNTR, 32'd0, "os_c0a");
    rd(TIMER_CNTR, 32'd0, "os_c0b");
    rd(TIMER_CNTR, 32'd0, "os_c0c");
    rd(TIMER_CNTR, 32'd1, "os_c1a");
    rd(TIMER_CNTR, 32'd1, "os_c1b");
    rd(TIMER_CNTR, 32'd1, "os_c1c");
    rd(TIMER_CNTR, 32'd0, "os_c0d");
    rd(TIMER_CR, 32'h0000_0202, "os_cr");
    rd(TIMER_CNTR, 32'd0, "os_hold1");
    rd(TIMER_CNTR, 32'd0, "os_hold2");
    rd(TIMER_SR, 32'd1, "os_sr");

    // Wrap through 0xFFFF_FFFF, match at 5 only
    wr(TIMER_SR, 32'h1);
    wr(TIMER_CMPR, 32'd5);
    wr(TIMER_CNTR, 32'hFFFF_FFFE);
    wr(TIMER_CR, 32'h1);
    rd(TIMER_CNTR, 32'hFFFF_FFFE, "wr_fe");
    rd(TIMER_CNTR, 32'hFFFF_FFFF, "wr_ff");
    for (int i = 0; i < 5; i++) begin
      rd(TIMER_CNTR, 32'(i), "wr_seq");
    end
    rd(TIMER_SR, 32'd0, "wr_nomatch");
    rd(TIMER_SR, 32'd1, "wr_match5");

    // Collisions
    wr(TIMER_CNTR, 32'h10);
    rd(TIMER_CNTR, 32'h10, "col_wr_tick");
    wr(TIMER_SR, 32'h1);
    wr(TIMER_CNTR, 32'd4);
    rd(TIMER_SR, 32'd0, "col_sr_clr");
    wr(TIMER_SR, 32'h1);
    rd(TIMER_SR, 32'd1, "col_w1c_set");

    // Async reset mid-count
    wr(TIMER_CR, 32'h4);
    wr(TIMER_CMPR, 32'd100);
    wr(TIMER_CNTR, 32'd7);
    rd(TIMER_CNTR, 32'd7, "pre_rst_cntr");
    chk_irq("pre_rst_irq", 1'b1);
    rd(TIMER_CMPR, 32'd100, "lost");
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata", rdata, 32'h0);
    chk_irq("async_irq", 1'b0);
    sb.delete();
    requested_reg = TIMER_NONE;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(TIMER_CR, 32'h0, "post_cr");
    rd(TIMER_SR, 32'h0, "post_sr");
    rd(TIMER_CNTR, 32'h0, "post_cntr");
    rd(TIMER_CMPR, 32'hFFFF_FFFF, "post_cmpr");
    cyc(TIMER_NONE, 1'b0, 32'h0, 32'h0, "idle");
    cyc(TIMER_NONE, 1'b0, 32'h0, 32'h0, "idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
